hilo_mult_ctrl: RTL and testbench

- Sequencing controller for the pipelined MIPS core's multi-cycle multiply unit and HI/LO register pair.
- Serves MULTU (product replaces HI/LO) and MADDU (product added to HI/LO) with an iterative shift-add multiplier, one multiplier bit per cycle.
- Serves MFHI/MFLO reads of HI/LO.
- Generates the pipeline stall that holds the EX-stage instruction while the unit is busy.

---
 rtl/hilo_mult_ctrl.sv | 119 +++++++++++
 tb/tb_hilo_mult_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_ctrl.sv
// hilo_mult_ctrl
//   Sequencing controller for the multi-cycle multiply unit and the HI/LO
//   register pair. MULTU replaces HI/LO with op_a*op_b; MADDU adds the
//   product to HI/LO (carry-out dropped). The multiply is shift-add, one
//   multiplier bit per cycle, so every operation takes WIDTH RUN cycles
//   plus one WB cycle. MFHI/MFLO reads come straight off the registers.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          MULTU/MADDU in EX (sampled only while idle)
//   accumulate     1 = MADDU, 0 = MULTU
//   op_a, op_b     unsigned multiplicand / multiplier
//   mf_req, mf_sel MFHI/MFLO in EX; mf_sel 1 = HI, 0 = LO
//   mf_data        selected HI/LO, meaningful when stall = 0
//   hi, lo         HI/LO registers
//   busy           operation in flight (RUN or WB)
//   done           one-cycle pulse during WB
//   stall          hold IF/ID/EX while a new request meets a busy unit
module hilo_mult_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               acc;

    // busy and done are registered alongside the state so they are glitch-free
    // stage outputs; they track RUN/WB and WB respectively.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            acc    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, op_a};
                        mplier <= op_b;
                        acc    <= accumulate;
                        prod   <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        done  <= 1'b1;
                        state <= WB;
                    end
                end
                WB: begin
                    if (acc) begin
                        {hi, lo} <= {hi, lo} + prod;
                    end else begin
                        {hi, lo} <= prod;
                    end
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // No HI/LO forwarding: a read during WB stalls and sees the new value
    // on the following idle cycle.
    always_comb begin
        stall   = busy & (start | mf_req);
        mf_data = mf_sel ? hi : lo;
    end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// tb_hilo_mult_ctrl
//   Self-checking bench for hilo_mult_ctrl. A transaction-level model
//   (accepted op -> fixed latency -> {hi,lo} = product or sum) is compared
//   against the DUT every cycle; directed scenarios pin literal results.
module tb_hilo_mult_ctrl;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         accumulate = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         mf_req = 1'b0;
    logic         mf_sel = 1'b0;
    logic [W-1:0] mf_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    hilo_mult_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .accumulate(accumulate),
        .op_a      (op_a),
        .op_b      (op_b),
        .mf_req    (mf_req),
        .mf_sel    (mf_sel),
        .mf_data   (mf_data),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_rem counts the busy cycles still to go for the accepted operation.
    logic [2*W-1:0] m_hilo = '0;
    logic [2*W-1:0] m_prod = '0;
    logic           m_acc  = 1'b0;
    int unsigned    m_rem  = 0;
    logic           armed  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  = 0;
            m_hilo = '0;
            armed  = 1'b1;
        end else if (m_rem != 0) begin
            if (m_rem == 1) begin
                m_hilo = m_acc ? (m_hilo + m_prod) : m_prod;
            end
            m_rem = m_rem - 1;
        end else if (start) begin
            m_prod = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
            m_acc  = accumulate;
            m_rem  = LAT;
        end
    end

    always @(negedge clk) begin
        if (armed && !rst) begin
            chk("busy", {63'd0, busy}, {63'd0, m_rem != 0});
            chk("done", {63'd0, done}, {63'd0, m_rem == 1});
            chk("stall", {63'd0, stall}, {63'd0, (m_rem != 0) && (start || mf_req)});
            chk("hilo", {hi, lo}, m_hilo);
            chk("mf_data", {32'd0, mf_data}, {32'd0, mf_sel ? m_hilo[2*W-1:W] : m_hilo[W-1:0]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and hold start until the edge that accepts it.
    // Returns #1 after the accepting edge with start deasserted.
    task automatic issue(input logic acc, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 1'b0;
        tick();
        start = 1'b1;
        accumulate = acc;
        op_a = a;
        op_b = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("issue_timeout", 64'd1, 64'd0);
        tick();
        start = 1'b0;
    endtask

    // Leaves the caller at the negedge of the first idle cycle.
    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic acc, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(acc, a, b);
        wait_idle();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 4)
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        int nd;
        bit ok;

        // Reset
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);

        // Full-scale MULTU: busy width and done pulse count
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        nb = 0;
        nd = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("full_finished", {63'd0, ok}, 64'd1);
        chk("full_busy_cycles", 64'(nb), 64'd33);
        chk("full_done_pulses", 64'(nd), 64'd1);
        chk("full_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        chk("full_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);

        // MADDU 3*5 on top of the full-scale product
        run_op(1'b1, 32'd3, 32'd5);
        chk("maddu_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        chk("maddu_lo", {32'd0, lo}, 64'h0000_0000_0000_0010);

        // MADDU wrap: carry out of 64 bits dropped
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("wrap_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFC);
        chk("wrap_lo", {32'd0, lo}, 64'h0000_0000_0000_0002);

        // MFHI / MFLO held during busy
        for (int s = 1; s >= 0; s--) begin
            issue(1'b0, 32'h0001_0000, 32'h0001_0000);
            mf_req = 1'b1;
            mf_sel = s[0];
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (!busy) begin
                    ok = 1'b1;
                    break;
                end
                chk("mf_stall_busy", {63'd0, stall}, 64'd1);
            end
            chk("mf_finished", {63'd0, ok}, 64'd1);
            chk("mf_stall_idle", {63'd0, stall}, 64'd0);
            chk(s[0] ? "mfhi_data" : "mflo_data", {32'd0, mf_data}, s[0] ? 64'd1 : 64'd0);
            tick();
            mf_req = 1'b0;
        end

        // Back-to-back: second start held while the first runs
        issue(1'b0, 32'd2, 32'd3);
        tick();
        start = 1'b1;
        accumulate = 1'b0;
        op_a = 32'd7;
        op_b = 32'd6;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            chk("b2b_stall", {63'd0, stall}, 64'd1);
        end
        chk("b2b_finished", {63'd0, ok}, 64'd1);
        chk("b2b_first_lo", {32'd0, lo}, 64'd6);
        chk("b2b_idle_stall", {63'd0, stall}, 64'd0);
        tick();
        start = 1'b0;
        wait_idle();
        chk("b2b_final_lo", {32'd0, lo}, 64'd42);
        chk("b2b_final_hi", {32'd0, hi}, 64'd0);

        // Reset mid-operation at RUN edge E10
        issue(1'b0, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("midrst_no_done", 64'(nd), 64'd0);
        run_op(1'b0, 32'd4, 32'd4);
        chk("after_rst_lo", {32'd0, lo}, 64'd16);
        chk("after_rst_hi", {32'd0, hi}, 64'd0);

        // Randomised traffic, checked by the per-cycle model comparison
        for (int i = 0; i < 1500; i++) begin
            tick();
            start      = ($urandom % 4) == 0;
            accumulate = $urandom % 2;
            op_a       = pick();
            op_b       = pick();
            mf_req     = $urandom % 2;
            mf_sel     = $urandom % 2;
        end
        tick();
        start  = 1'b0;
        mf_req = 1'b0;
        wait_idle();
        chk("final_hilo", {hi, lo}, m_hilo);

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

endmodule
